// File: rtl/serial_word_rx.sv
// serial_word_rx
//   Oversampling serial receiver: start bit, `size` data bits LSB first,
//   optional even-parity bit, one stop bit. Each good word is offered on a
//   one-entry valid/ready buffer.
//
//   Optional feature macro: SERIAL_WORD_RX_PARITY_EN
//     defined   -> an even-parity bit follows the data bits, and the
//                  parity_err output is present.
//     undefined -> frame is start + data + stop only, and there is no
//                  parity_err port.
//
// Ports:
//   clk        system clock, all logic on posedge
//   r          synchronous active-high reset
//   rxd        asynchronous serial input, idle high
//   out_ready  consumer accepts out_word this cycle
//   out_word   received word
//   out_valid  out_word holds an unconsumed word
//   frame_err  one-cycle pulse, stop bit sampled low
//   overrun    one-cycle pulse, word dropped because the buffer was full
//   parity_err one-cycle pulse with the stop decision on a parity mismatch
//              (only with SERIAL_WORD_RX_PARITY_EN)
module serial_word_rx #(
    parameter int size         = 32,
    parameter int clks_per_bit = 16
) (
    input  logic            clk,
    input  logic            r,
    input  logic            rxd,
    input  logic            out_ready,
    output logic [size-1:0] out_word,
    output logic            out_valid,
    output logic            frame_err,
`ifdef SERIAL_WORD_RX_PARITY_EN
    output logic            parity_err,
`endif
    output logic            overrun
);

    localparam int CW = $clog2(clks_per_bit);
    localparam int IW = (size > 1) ? $clog2(size) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(clks_per_bit - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(clks_per_bit / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(size - 1);

`ifdef SERIAL_WORD_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
    } state_t;
`endif

    state_t          state;
    state_t          state_next;
    logic            rx_p0;
    logic            rx_p1;
    logic            rx_s;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   bit_idx;
    logic [size-1:0] sh;
    logic [size-1:0] sh_next;
    logic            mid_hit;
    logic            end_hit;
    logic            data_smp;
    logic            stop_smp;
    logic            stop_good;
    logic            stop_bad;
`ifdef SERIAL_WORD_RX_PARITY_EN
    logic            par_smp;
    logic            par_bit;
`endif

    // ---- stage p0/p1: two-flop synchronizer, idles high out of reset ----
    always_ff @(posedge clk) begin
        if (r) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rxd;
            rx_p1 <= rx_p0;
        end
    end

    assign rx_s    = rx_p1;
    assign mid_hit = (cnt == CNT_MID);
    assign end_hit = (cnt == CNT_LAST);

    // ---- framing FSM: state register ----
    always_ff @(posedge clk) begin
        if (r) state <= S_IDLE;
        else   state <= state_next;
    end

    // ---- framing FSM: next state ----
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (!rx_s) state_next = S_START;
            // Half a bit into the start bit: a line back high was a glitch.
            S_START: if (mid_hit) state_next = rx_s ? S_IDLE : S_DATA;
            S_DATA:
                if (end_hit && (bit_idx == IDX_LAST)) begin
`ifdef SERIAL_WORD_RX_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_STOP;
`endif
                end
`ifdef SERIAL_WORD_RX_PARITY_EN
            S_PARITY: if (end_hit) state_next = S_STOP;
`endif
            S_STOP:  if (end_hit) state_next = rx_s ? S_IDLE : S_BREAK;
            // A line held low is waited out here so it cannot frame a word.
            S_BREAK: if (rx_s) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---- framing FSM: sample strobes ----
    always_comb begin
        data_smp  = (state == S_DATA) && end_hit;
        stop_smp  = (state == S_STOP) && end_hit;
        stop_good = stop_smp && rx_s;
        stop_bad  = stop_smp && !rx_s;
`ifdef SERIAL_WORD_RX_PARITY_EN
        par_smp   = (state == S_PARITY) && end_hit;
`endif
    end

    // Oversampling counter restarts on every state change so sampling
    // points stay aligned to the detected start edge.
    always_ff @(posedge clk) begin
        if (r)                        cnt <= '0;
        else if (state_next != state) cnt <= '0;
        else if (end_hit)             cnt <= '0;
        else                          cnt <= cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (r)                     bit_idx <= '0;
        else if (state == S_START) bit_idx <= '0;
        else if (data_smp)         bit_idx <= bit_idx + IW'(1);
    end

    // New bit enters at the top so the first received bit lands in sh[0].
    always_comb begin
        sh_next           = sh >> 1;
        sh_next[size-1]   = rx_s;
    end

    // ---- stage: deserializer datapath ----
    always_ff @(posedge clk) begin
        if (data_smp) sh <= sh_next;
`ifdef SERIAL_WORD_RX_PARITY_EN
        if (par_smp)  par_bit <= rx_s;
`endif
    end

    // ---- stage: output buffer and status pulses ----
    always_ff @(posedge clk) begin
        if (r) begin
            out_word   <= '0;
            out_valid  <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err  <= stop_bad;
            overrun    <= stop_good && out_valid && !out_ready;
`ifdef SERIAL_WORD_RX_PARITY_EN
            parity_err <= stop_smp && ((^sh) ^ par_bit);
`endif
            // A consume in the delivery cycle frees the slot without a bubble.
            if (stop_good && (!out_valid || out_ready)) begin
                out_word  <= sh;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_rx.sv
// tb_serial_word_rx
//   Directed bench for serial_word_rx with size=8, clks_per_bit=4.
//   Frames are driven bit by bit on the falling edge; a posedge monitor
//   tallies handshakes and status pulses exactly as the DUT sees them.
//   Parity checks are included when SERIAL_WORD_RX_PARITY_EN is defined.
module tb_serial_word_rx;

    localparam int SIZE = 8;
    localparam int CPB  = 4;

    logic            clk = 1'b0;
    logic            r;
    logic            rxd;
    logic            out_ready;
    logic [SIZE-1:0] out_word;
    logic            out_valid;
    logic            frame_err;
    logic            overrun;
`ifdef SERIAL_WORD_RX_PARITY_EN
    logic            parity_err;
`endif

    int checks = 0;
    int errors = 0;

    int              n_acc  = 0;
    int              n_ferr = 0;
    int              n_ovr  = 0;
    int              n_perr = 0;
    logic [SIZE-1:0] last_acc = '0;

    int b_acc, b_ferr, b_ovr, b_perr;

    serial_word_rx #(.size(SIZE), .clks_per_bit(CPB)) dut (
        .clk       (clk),
        .r         (r),
        .rxd       (rxd),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_valid (out_valid),
        .frame_err (frame_err),
`ifdef SERIAL_WORD_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_acc    <= n_acc + 1;
            last_acc <= out_word;
        end
        if (frame_err === 1'b1) n_ferr <= n_ferr + 1;
        if (overrun === 1'b1)   n_ovr  <= n_ovr + 1;
`ifdef SERIAL_WORD_RX_PARITY_EN
        if (parity_err === 1'b1) n_perr <= n_perr + 1;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_acc  = n_acc;
        b_ferr = n_ferr;
        b_ovr  = n_ovr;
        b_perr = n_perr;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Ends on the falling edge inside the stop-bit sample cycle.
    task automatic send_frame(input logic [SIZE-1:0] w, input logic stop, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < SIZE; i++) send_bit(w[i]);
`ifdef SERIAL_WORD_RX_PARITY_EN
        send_bit((^w) ^ par_flip);
`endif
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        r         = 1'b1;
        rxd       = 1'b1;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_out_word",  32'(out_word),  32'h0);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_frame_err", 32'(frame_err), 32'h0);
        chk("reset_overrun",   32'(overrun),   32'h0);
        r = 1'b0;
        idle(4);

        // Good frame
        out_ready = 1'b1;
        snap();
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(4);
        chk("good_acc_count", 32'(n_acc - b_acc),   32'd1);
        chk("good_word",      32'(last_acc),        32'hA5);
        chk("good_frame_err", 32'(n_ferr - b_ferr), 32'd0);
        chk("good_overrun",   32'(n_ovr - b_ovr),   32'd0);

        // One-cycle glitch while idle is rejected
        snap();
        rxd = 1'b0;
        @(negedge clk);
        idle(12);
        chk("glitch_no_valid", 32'(out_valid),     32'h0);
        chk("glitch_no_acc",   32'(n_acc - b_acc), 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(4);
        chk("after_glitch_word", 32'(last_acc),    32'h3C);

        // Bad stop bit followed by a held-low line
        snap();
        send_frame(8'h5A, 1'b0, 1'b0);
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        idle(8);
        chk("badstop_no_acc", 32'(n_acc - b_acc),   32'd0);
        chk("badstop_ferr",   32'(n_ferr - b_ferr), 32'd1);
        send_frame(8'h11, 1'b1, 1'b0);
        idle(4);
        chk("after_break_word", 32'(last_acc),        32'h11);
        chk("after_break_ferr", 32'(n_ferr - b_ferr), 32'd1);

        // Overrun: second word dropped while the first is held
        out_ready = 1'b0;
        snap();
        send_frame(8'h01, 1'b1, 1'b0);
        idle(4);
        send_frame(8'h02, 1'b1, 1'b0);
        idle(4);
        chk("ovr_valid",   32'(out_valid),     32'h1);
        chk("ovr_word",    32'(out_word),      32'h01);
        chk("ovr_pulse",   32'(n_ovr - b_ovr), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("ovr_drain_valid", 32'(out_valid), 32'h0);
        chk("ovr_drain_word",  32'(last_acc),  32'h01);

        // Consume and deliver in the same cycle
        out_ready = 1'b0;
        idle(4);
        snap();
        send_frame(8'h01, 1'b1, 1'b0);
        idle(4);
        send_frame(8'h02, 1'b1, 1'b0);
        out_ready = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        chk("simul_valid", 32'(out_valid),     32'h1);
        chk("simul_word",  32'(out_word),      32'h02);
        chk("simul_no_ovr", 32'(n_ovr - b_ovr), 32'd0);
        @(negedge clk);
        chk("simul_drain_valid", 32'(out_valid), 32'h0);
        chk("simul_acc_count",   32'(n_acc - b_acc), 32'd2);

        // Reset during data bit 4 with a word pending
        out_ready = 1'b0;
        idle(4);
        send_frame(8'h33, 1'b1, 1'b0);
        idle(4);
        chk("pre_reset_valid", 32'(out_valid), 32'h1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h96 >> i));
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        r = 1'b1;
        @(negedge clk);
        chk("midreset_out_word",  32'(out_word),  32'h0);
        chk("midreset_out_valid", 32'(out_valid), 32'h0);
        chk("midreset_frame_err", 32'(frame_err), 32'h0);
        chk("midreset_overrun",   32'(overrun),   32'h0);
        r = 1'b0;
        out_ready = 1'b1;
        idle(8);
        snap();
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(4);
        chk("post_reset_acc",  32'(n_acc - b_acc), 32'd1);
        chk("post_reset_word", 32'(last_acc),      32'hFF);

`ifdef SERIAL_WORD_RX_PARITY_EN
        chk("parity_clean_so_far", 32'(n_perr), 32'd0);
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        idle(4);
        chk("parity_err_pulse", 32'(n_perr - b_perr), 32'd1);
        chk("parity_word",      32'(last_acc),        32'h07);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
